// File: rtl/hps_f2h_reset_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : hps_f2h_reset_req_gen
// Purpose  : FPGA-side generator for the HPS f2h cold/warm/debug reset-request
//            inputs (all active-low). A raw push-button is synchronised,
//            debounced and its hold time classified: a long hold issues a cold
//            request, a medium hold a warm request and a short hold is ignored.
//            A software debug-reset strobe is forwarded as a debug request.
//            Every request is a fixed-width low pulse followed by a lockout
//            window during which all inputs are ignored.
// Ports    : clk_clk                           in  system clock
//            reset_reset_n                     in  async active-low reset
//            button_n                          in  raw async button, 0 = pressed
//            debug_req                         in  single-cycle debug strobe
//            hps_0_f2h_cold_reset_req_reset_n  out cold request, active-low
//            hps_0_f2h_warm_reset_req_reset_n  out warm request, active-low
//            hps_0_f2h_debug_reset_req_reset_n out debug request, active-low
//            busy                              out 1 whenever FSM not IDLE
//            last_req [1:0]                    out 00 none,01 warm,10 cold,11 debug
// Revision : 1.0 - initial release
// ============================================================================
module hps_f2h_reset_req_gen #(
  parameter int unsigned DEBOUNCE_CYCLES  = 50000,
  parameter int unsigned WARM_HOLD_CYCLES = 25000000,
  parameter int unsigned COLD_HOLD_CYCLES = 150000000,
  parameter int unsigned PULSE_CYCLES     = 64,
  parameter int unsigned LOCKOUT_CYCLES   = 1024
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       button_n,
  input  logic       debug_req,
  output logic       hps_0_f2h_cold_reset_req_reset_n,
  output logic       hps_0_f2h_warm_reset_req_reset_n,
  output logic       hps_0_f2h_debug_reset_req_reset_n,
  output logic       busy,
  output logic [1:0] last_req
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W  = $clog2(COLD_HOLD_CYCLES + 1);
  localparam int unsigned PULSE_W = $clog2(PULSE_CYCLES + 1);
  localparam int unsigned LOCK_W  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]    C_DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  C_HOLD_COLD  = HOLD_W'(COLD_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  C_HOLD_WARM  = HOLD_W'(WARM_HOLD_CYCLES);
  localparam logic [PULSE_W-1:0] C_PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  C_LOCK_LAST  = LOCK_W'(LOCKOUT_CYCLES - 1);

  localparam logic [1:0] C_REQ_NONE  = 2'b00;
  localparam logic [1:0] C_REQ_WARM  = 2'b01;
  localparam logic [1:0] C_REQ_COLD  = 2'b10;
  localparam logic [1:0] C_REQ_DEBUG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_PULSE   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // Synchroniser and debouncer
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              db_level_q, db_level_d;   // 1 = released
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;

  // Request FSM
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              cold_n_q, cold_n_d;
  logic              warm_n_q, warm_n_d;
  logic              debug_n_q, debug_n_d;
  logic              busy_q, busy_d;
  logic [1:0]        last_req_q, last_req_d;

  logic              w_pressed;
  logic              w_start;
  logic [1:0]        w_kind;

  always_comb begin
    sync1_d     = button_n;
    sync2_d     = sync1_q;
    db_level_d  = db_level_q;
    db_cnt_d    = db_cnt_q;
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    cold_n_d    = cold_n_q;
    warm_n_d    = warm_n_q;
    debug_n_d   = debug_n_q;
    last_req_d  = last_req_q;
    w_start     = 1'b0;
    w_kind      = C_REQ_NONE;
    w_pressed   = ~db_level_q;

    // Debounce runs in every state: the level only follows the synchronised
    // input after DEBOUNCE_CYCLES consecutive differing samples.
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == C_DB_LAST) begin
      db_level_d = sync2_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A debug strobe wins over a press seen in the same cycle.
        if (debug_req) begin
          w_start = 1'b1;
          w_kind  = C_REQ_DEBUG;
        end else if (w_pressed) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (!w_pressed) begin
          if (hold_cnt_q >= C_HOLD_COLD) begin
            w_start = 1'b1;
            w_kind  = C_REQ_COLD;
          end else if (hold_cnt_q >= C_HOLD_WARM) begin
            w_start = 1'b1;
            w_kind  = C_REQ_WARM;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hold_cnt_q != C_HOLD_COLD) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q == C_PULSE_LAST) begin
          cold_n_d   = 1'b1;
          warm_n_d   = 1'b1;
          debug_n_d  = 1'b1;
          state_d    = ST_LOCKOUT;
          lock_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        // Returning to IDLE with the button still down starts a fresh HOLD
        // measurement there; nothing from before the pulse is carried over.
        if (lock_cnt_q == C_LOCK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Requests are launched from flops so the first low cycle is the one
    // right after the deciding transition.
    if (w_start) begin
      state_d     = ST_PULSE;
      pulse_cnt_d = '0;
      last_req_d  = w_kind;
      cold_n_d    = (w_kind != C_REQ_COLD);
      warm_n_d    = (w_kind != C_REQ_WARM);
      debug_n_d   = (w_kind != C_REQ_DEBUG);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      db_level_q  <= 1'b1;
      db_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      lock_cnt_q  <= '0;
      cold_n_q    <= 1'b1;
      warm_n_q    <= 1'b1;
      debug_n_q   <= 1'b1;
      busy_q      <= 1'b0;
      last_req_q  <= C_REQ_NONE;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      cold_n_q    <= cold_n_d;
      warm_n_q    <= warm_n_d;
      debug_n_q   <= debug_n_d;
      busy_q      <= busy_d;
      last_req_q  <= last_req_d;
    end
  end

  assign hps_0_f2h_cold_reset_req_reset_n  = cold_n_q;
  assign hps_0_f2h_warm_reset_req_reset_n  = warm_n_q;
  assign hps_0_f2h_debug_reset_req_reset_n = debug_n_q;
  assign busy                              = busy_q;
  assign last_req                          = last_req_q;

endmodule
`default_nettype wire
